// File: rtl/pwm_rate_ctrl_pkg.sv
// Shared constants for the rate controller: rate range and button FSM encoding.
package pwm_rate_ctrl_pkg;

    localparam int RATE_W = 4;
    localparam logic [RATE_W-1:0] RATE_MAX = 4'hF;
    localparam logic [RATE_W-1:0] RATE_MIN = 4'h0;

    // Button FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Saturating one-step update; simultaneous up/down requests cancel.
    function automatic logic [RATE_W-1:0] rate_next(
        input logic [RATE_W-1:0] cur,
        input logic              up,
        input logic              dn
    );
        logic [RATE_W-1:0] nxt;
        nxt = cur;
        if (up && !dn && (cur != RATE_MAX)) begin
            nxt = cur + RATE_W'(1);
        end else if (dn && !up && (cur != RATE_MIN)) begin
            nxt = cur - RATE_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pwm_rate_ctrl_btn_step.sv
// One push-button front end: 2-FF synchroniser, debounce, and a hold/repeat
// FSM that turns a press into single-cycle step pulses.
module btn_step
    import pwm_rate_ctrl_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] HOLD_CYCLES     = 24'd5000000,
    parameter logic [23:0] REPEAT_CYCLES   = 24'd2500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic step,
    output logic level
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [23:0] TM_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TM_W = $clog2(TM_MAX) + 1;

    // Terminal counts: the counter value on the edge where the event fires.
    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 16'd1);
    localparam logic [TM_W-1:0] HOLD_LAST   = TM_W'(HOLD_CYCLES - 24'd1);
    localparam logic [TM_W-1:0] REPEAT_LAST = TM_W'(REPEAT_CYCLES - 24'd1);

    logic            sync1_q, sync2_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic [1:0]      state_q, state_d;
    logic [TM_W-1:0] timer_q, timer_d;
    logic            step_q, step_d;

    // Debounce: count consecutive cycles the synced input disagrees with the
    // accepted level; any agreement restarts the count.
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (sync2_q == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            level_d  = ~level_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // Hold/repeat FSM: step on press, after the hold delay, then periodically.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        step_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_q) begin
                    state_d = ST_HOLD;
                    timer_d = '0;
                    step_d  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!level_q) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q == HOLD_LAST) begin
                    state_d = ST_REPEAT;
                    timer_d = '0;
                    step_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TM_W'(1);
                end
            end
            ST_REPEAT: begin
                if (!level_q) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q == REPEAT_LAST) begin
                    timer_d = '0;
                    step_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TM_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // State registers; stage 1 of the synchroniser carries no logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            step_q   <= 1'b0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            state_q  <= state_d;
            timer_q  <= timer_d;
            step_q   <= step_d;
        end
    end

    assign step  = step_q;
    assign level = level_q;

endmodule

// File: rtl/pwm_rate_ctrl.sv
// Up/down button controlled 4-bit rate for the pwm stage, saturating at 0..15.
module pwm_rate_ctrl
    import pwm_rate_ctrl_pkg::*;
#(
    parameter logic [15:0]       DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0]       HOLD_CYCLES     = 24'd5000000,
    parameter logic [23:0]       REPEAT_CYCLES   = 24'd2500000,
    parameter logic [RATE_W-1:0] RATE_RESET      = 4'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_up,
    input  logic              btn_down,
    output logic [RATE_W-1:0] rate,
    output logic              at_max,
    output logic              at_min
);

    logic              up_step, dn_step;
    // Debounced levels are part of the front-end interface but the rate
    // register only needs the step pulses.
    logic [1:0]        unused_btn_level;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic              at_max_q, at_max_d;
    logic              at_min_q, at_min_d;

    btn_step #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_up (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_up),
        .step    (up_step),
        .level   (unused_btn_level[0])
    );

    btn_step #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_down (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_down),
        .step    (dn_step),
        .level   (unused_btn_level[1])
    );

    // Next rate and flags derived from the same next value so they stay aligned.
    always_comb begin
        rate_d   = rate_next(rate_q, up_step, dn_step);
        at_max_d = (rate_d == RATE_MAX);
        at_min_d = (rate_d == RATE_MIN);
    end

    // Rate register with its boundary flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rate_q   <= RATE_RESET;
            at_max_q <= (RATE_RESET == RATE_MAX);
            at_min_q <= (RATE_RESET == RATE_MIN);
        end else begin
            rate_q   <= rate_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
        end
    end

    assign rate   = rate_q;
    assign at_max = at_max_q;
    assign at_min = at_min_q;

endmodule
